// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : RV32I data-memory responder with valid/ready request and
//               response channels and a fixed programmable access latency.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_error
);

    localparam int         c_AW   = $clog2(DEPTH_WORDS);
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic        r_write;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_resp_valid;
    logic [31:0] r_resp_rdata;
    logic        r_resp_error;

    // Power-up contents are zero; reset deliberately leaves memory alone.
    logic [31:0] r_mem [DEPTH_WORDS] = '{default: '0};

    logic [c_AW-1:0] w_idx;
    logic [31:0]     w_word;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [31:0]     w_load;
    logic            w_oob;
    logic            w_misalign;
    logic            w_bad_f3;
    logic            w_err;
    logic            w_do_access;
    logic            w_we;
    logic [3:0]      w_be;
    logic [31:0]     w_wlanes;

    assign w_idx  = r_addr[c_AW+1:2];
    assign w_word = r_mem[w_idx];
    assign w_byte = w_word[{r_addr[1:0], 3'b000} +: 8];
    assign w_half = w_word[{r_addr[1], 4'b0000} +: 16];

    assign w_oob      = |r_addr[31:c_AW+2];
    assign w_misalign = ((r_funct3[1:0] == 2'b01) && r_addr[0]) ||
                        ((r_funct3[1:0] == 2'b10) && (r_addr[1:0] != 2'b00));
    assign w_bad_f3   = r_write ? (r_funct3 > 3'd2)
                                : ((r_funct3 == 3'd3) || (r_funct3[2:1] == 2'b11));
    assign w_err      = w_oob || w_misalign || w_bad_f3;

    always_comb begin
        w_load = 32'd0;
        case (r_funct3)
            3'd0:    w_load = {{24{w_byte[7]}}, w_byte};
            3'd1:    w_load = {{16{w_half[15]}}, w_half};
            3'd2:    w_load = w_word;
            3'd4:    w_load = {24'd0, w_byte};
            3'd5:    w_load = {16'd0, w_half};
            default: w_load = 32'd0;
        endcase
    end

    always_comb begin
        w_be     = 4'b0000;
        w_wlanes = r_wdata;
        case (r_funct3[1:0])
            2'b00: begin
                w_be     = 4'b0001 << r_addr[1:0];
                w_wlanes = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_be     = r_addr[1] ? 4'b1100 : 4'b0011;
                w_wlanes = {2{r_wdata[15:0]}};
            end
            2'b10:   w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    assign w_do_access = (r_state == c_BUSY) && (r_cnt == 4'd0);
    // Gating with reset aborts a store whose access edge coincides with reset.
    assign w_we        = !reset && w_do_access && r_write && !w_err;

    always_ff @(posedge clock) begin
        if (w_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][b*8 +: 8] <= w_wlanes[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= c_IDLE;
            r_cnt        <= 4'd0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'd0;
            r_resp_error <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (req_valid) begin
                        r_write  <= req_write;
                        r_funct3 <= req_funct3;
                        r_addr   <= req_addr;
                        r_wdata  <= req_wdata;
                        r_cnt    <= 4'(LATENCY);
                        r_state  <= c_BUSY;
                    end
                end
                c_BUSY: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_state      <= c_RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_error <= w_err;
                        r_resp_rdata <= (r_write || w_err) ? 32'd0 : w_load;
                    end
                end
                c_RESP: begin
                    if (resp_ready) begin
                        r_state      <= c_IDLE;
                        r_resp_valid <= 1'b0;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign req_ready  = (r_state == c_IDLE);
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_error = r_resp_error;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Directed self-checking bench for dmem_responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic        req_valid, req_ready, req_write, resp_valid, resp_ready, resp_error;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata, resp_rdata;

    logic        b_req_valid, b_req_ready, b_req_write, b_resp_valid, b_resp_ready, b_resp_error;
    logic [2:0]  b_req_funct3;
    logic [31:0] b_req_addr, b_req_wdata, b_resp_rdata;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int drv_n, last_cyc, mon_k;

    always @(posedge clock) cyc <= cyc + 1;

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u_dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_error(resp_error)
    );

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) u_dut_l0 (
        .clock(clock), .reset(reset),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
        .req_funct3(b_req_funct3), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
        .resp_rdata(b_resp_rdata), .resp_error(b_resp_error)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One complete transaction on the LATENCY=2 instance, response taken at once.
    task automatic access(input string tag, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rd, input logic exp_err);
        int n;
        check_eq({tag, ".req_ready"}, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_write  = wr;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        tick();
        req_valid = 1'b0;
        n = 0;
        while (!resp_valid && n < 20) begin
            tick();
            n++;
        end
        check_eq({tag, ".latency"}, 32'(n), 32'd3);
        check_eq({tag, ".rdata"}, resp_rdata, exp_rd);
        check_eq({tag, ".error"}, 32'(resp_error), 32'(exp_err));
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check_eq({tag, ".valid_drop"}, 32'(resp_valid), 32'd0);
    endtask

    logic        bw [6];
    logic [2:0]  bf [6];
    logic [31:0] ba [6];
    logic [31:0] bd [6];
    logic [31:0] be [6];

    initial begin
        bw[0] = 1; bf[0] = 3'd2; ba[0] = 32'h0; bd[0] = 32'hA5A5A5A5; be[0] = 32'h0;
        bw[1] = 1; bf[1] = 3'd2; ba[1] = 32'h4; bd[1] = 32'h01020304; be[1] = 32'h0;
        bw[2] = 0; bf[2] = 3'd2; ba[2] = 32'h0; bd[2] = 32'h0;        be[2] = 32'hA5A5A5A5;
        bw[3] = 0; bf[3] = 3'd2; ba[3] = 32'h4; bd[3] = 32'h0;        be[3] = 32'h01020304;
        bw[4] = 1; bf[4] = 3'd0; ba[4] = 32'h5; bd[4] = 32'hFFFFFF77; be[4] = 32'h0;
        bw[5] = 0; bf[5] = 3'd2; ba[5] = 32'h4; bd[5] = 32'h0;        be[5] = 32'h01027704;

        reset = 1'b1;
        req_valid = 0; req_write = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0; resp_ready = 0;
        b_req_valid = 0; b_req_write = 0; b_req_funct3 = 0; b_req_addr = 0; b_req_wdata = 0;
        b_resp_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check_eq("rst.req_ready", 32'(req_ready), 32'd1);
        check_eq("rst.resp_valid", 32'(resp_valid), 32'd0);
        check_eq("rst.resp_rdata", resp_rdata, 32'd0);
        check_eq("rst.resp_error", 32'(resp_error), 32'd0);

        access("sw10", 1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0, 0);
        access("lw10", 0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 0);
        access("sw10z", 1, 3'd2, 32'h10, 32'h0, 32'h0, 0);
        access("sb11", 1, 3'd0, 32'h11, 32'h00000080, 32'h0, 0);
        access("lb11", 0, 3'd0, 32'h11, 32'h0, 32'hFFFFFF80, 0);
        access("lbu11", 0, 3'd4, 32'h11, 32'h0, 32'h00000080, 0);
        access("lw10b", 0, 3'd2, 32'h10, 32'h0, 32'h00008000, 0);
        access("lh13", 0, 3'd1, 32'h13, 32'h0, 32'h0, 1);
        access("sw1002", 1, 3'd2, 32'h1002, 32'hCAFEF00D, 32'h0, 1);
        access("lw0", 0, 3'd2, 32'h0, 32'h0, 32'h0, 0);
        access("lw1000", 0, 3'd2, 32'h1000, 32'h0, 32'h0, 1);
        access("sw12mis", 1, 3'd2, 32'h12, 32'hFFFFFFFF, 32'h0, 1);
        access("st_f3_4", 1, 3'd4, 32'h10, 32'hFFFFFFFF, 32'h0, 1);
        access("lw10c", 0, 3'd2, 32'h10, 32'h0, 32'h00008000, 0);
        access("sh16", 1, 3'd1, 32'h16, 32'h1234CAFE, 32'h0, 0);
        access("lh16", 0, 3'd1, 32'h16, 32'h0, 32'hFFFFCAFE, 0);
        access("lhu16", 0, 3'd5, 32'h16, 32'h0, 32'h0000CAFE, 0);
        access("lw14", 0, 3'd2, 32'h14, 32'h0, 32'hCAFE0000, 0);
        access("ld_f3_3", 0, 3'd3, 32'h14, 32'h0, 32'h0, 1);

        // Stall the response and try to sneak a store in meanwhile.
        req_valid = 1; req_write = 0; req_funct3 = 3'd2; req_addr = 32'h10;
        tick();
        req_valid = 0;
        drv_n = 0;
        while (!resp_valid && drv_n < 20) begin
            tick();
            drv_n++;
        end
        req_valid = 1; req_write = 1; req_funct3 = 3'd2; req_addr = 32'h10; req_wdata = 32'h11111111;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("stall.resp_valid", 32'(resp_valid), 32'd1);
            check_eq("stall.rdata", resp_rdata, 32'h00008000);
            check_eq("stall.req_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 0;
        resp_ready = 1;
        tick();
        resp_ready = 0;
        check_eq("stall.exit_valid", 32'(resp_valid), 32'd0);
        check_eq("stall.exit_ready", 32'(req_ready), 32'd1);
        access("lw10d", 0, 3'd2, 32'h10, 32'h0, 32'h00008000, 0);

        // Reset lands on the access edge of a store; a request rides along with reset.
        req_valid = 1; req_write = 1; req_funct3 = 3'd2; req_addr = 32'h20; req_wdata = 32'h12345678;
        tick();
        req_valid = 0;
        tick();
        tick();
        reset = 1;
        req_valid = 1; req_write = 0; req_addr = 32'h20;
        tick();
        reset = 0;
        check_eq("abort.req_ready", 32'(req_ready), 32'd1);
        check_eq("abort.resp_valid", 32'(resp_valid), 32'd0);
        req_valid = 0;
        tick();
        tick();
        check_eq("abort.no_resp", 32'(resp_valid), 32'd0);
        access("lw20", 0, 3'd2, 32'h20, 32'h0, 32'h0, 0);

        // Back-to-back stream on the LATENCY=0 instance.
        last_cyc = 0;
        mon_k    = 0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    b_req_write  = bw[i];
                    b_req_funct3 = bf[i];
                    b_req_addr   = ba[i];
                    b_req_wdata  = bd[i];
                    b_req_valid  = 1'b1;
                    drv_n = 0;
                    while (!b_req_ready && drv_n < 20) begin
                        tick();
                        drv_n++;
                    end
                    tick();
                    if (i > 0) check_eq("b2b.interval", 32'(cyc - last_cyc), 32'd3);
                    last_cyc = cyc;
                end
                b_req_valid = 1'b0;
            end
            begin
                for (int c = 0; c < 40; c++) begin
                    @(negedge clock);
                    if (b_resp_valid) begin
                        if (mon_k < 6) begin
                            check_eq("b2b.rdata", b_resp_rdata, be[mon_k]);
                            check_eq("b2b.error", 32'(b_resp_error), 32'd0);
                        end
                        mon_k++;
                    end
                end
                check_eq("b2b.count", 32'(mon_k), 32'd6);
            end
        join

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
